// File: rtl/game_2048_input_ctrl_if.sv
// Button-to-command interface for the 2048 input controller.
// The controller is the command master; the button source / core side is the slave.
`timescale 1ns/1ps
interface game_2048_input_ctrl_if;
  logic       btn_up;
  logic       btn_left;
  logic       btn_down;
  logic       btn_right;
  logic       btn_cheat;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       cheat_valid;
  logic       busy;

  modport master (
    input  btn_up, btn_left, btn_down, btn_right, btn_cheat,
    output move_valid, move_dir, cheat_valid, busy
  );

  modport slave (
    output btn_up, btn_left, btn_down, btn_right, btn_cheat,
    input  move_valid, move_dir, cheat_valid, busy
  );
endinterface

// File: rtl/game_2048_input_ctrl.sv
// Synchronises, debounces and arbitrates five push-buttons into single-cycle
// move/cheat strobes for game_2048_core, with a post-command cooldown.
`timescale 1ns/1ps
module game_2048_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned COOLDOWN_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  game_2048_input_ctrl_if.master        bus
);

  localparam int unsigned NB    = 5;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CD_W  = $clog2(COOLDOWN_CYCLES + 1);
  localparam int unsigned I_UP    = 0;
  localparam int unsigned I_LEFT  = 1;
  localparam int unsigned I_DOWN  = 2;
  localparam int unsigned I_CHEAT = 4;

  typedef enum logic [1:0] {IDLE, FIRE, COOLDOWN} state_e;

  logic [NB-1:0]   raw;
  logic [NB-1:0]   sync1_q, sync1_d;
  logic [NB-1:0]   sync2_q, sync2_d;
  logic [NB-1:0]   db_q, db_d;
  logic [NB-1:0]   db_prev_q, db_prev_d;
  logic [DB_W-1:0] cnt_q [NB];
  logic [DB_W-1:0] cnt_d [NB];
  logic [NB-1:0]   press_c;

  state_e          state_q, state_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic            move_valid_q, move_valid_d;
  logic            cheat_valid_q, cheat_valid_d;
  logic [1:0]      move_dir_q, move_dir_d;
  logic            busy_q, busy_d;

  assign raw = {bus.btn_cheat, bus.btn_right, bus.btn_down, bus.btn_left, bus.btn_up};

  // Per-button synchroniser and stability counter; only a full-length mismatch moves db.
  always_comb begin
    sync1_d   = raw;
    sync2_d   = sync1_q;
    db_d      = db_q;
    db_prev_d = db_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign press_c = db_q & ~db_prev_q;

  // Command FSM: fixed-priority pick in IDLE, one-cycle strobe, then a blind cooldown.
  always_comb begin
    state_d       = state_q;
    cd_d          = cd_q;
    move_valid_d  = 1'b0;
    cheat_valid_d = 1'b0;
    move_dir_d    = move_dir_q;
    busy_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (|press_c) begin
          state_d = FIRE;
          busy_d  = 1'b1;
          if (press_c[I_CHEAT]) begin
            cheat_valid_d = 1'b1;
          end else begin
            move_valid_d = 1'b1;
            if (press_c[I_UP])        move_dir_d = 2'd0;
            else if (press_c[I_LEFT]) move_dir_d = 2'd1;
            else if (press_c[I_DOWN]) move_dir_d = 2'd2;
            else                      move_dir_d = 2'd3;
          end
        end
      end
      FIRE: begin
        state_d = COOLDOWN;
        cd_d    = '0;
        busy_d  = 1'b1;
      end
      COOLDOWN: begin
        if (cd_q == CD_W'(COOLDOWN_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          cd_d   = cd_q + CD_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      db_q          <= '0;
      db_prev_q     <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      state_q       <= IDLE;
      cd_q          <= '0;
      move_valid_q  <= 1'b0;
      cheat_valid_q <= 1'b0;
      move_dir_q    <= 2'd0;
      busy_q        <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      db_q          <= db_d;
      db_prev_q     <= db_prev_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      state_q       <= state_d;
      cd_q          <= cd_d;
      move_valid_q  <= move_valid_d;
      cheat_valid_q <= cheat_valid_d;
      move_dir_q    <= move_dir_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.move_valid  = move_valid_q;
  assign bus.cheat_valid = cheat_valid_q;
  assign bus.move_dir    = move_dir_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/game_2048_input_ctrl.md
Name: game_2048_input_ctrl

Overview:
Front-end input stage for game_2048_core. It synchronises and debounces five raw push-buttons (four directions and cheat), detects press edges, and arbitrates them. It emits single-cycle move_valid/move_dir or cheat_valid pulses, with a guaranteed cooldown so the core's MOVE/RAND sequence completes before the next command. Outputs connect directly to the core's move_valid, move_dir and cheat_valid inputs.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles required to accept a level change (10 ms at 100 MHz); must be >= 1
COOLDOWN_CYCLES, 4, idle cycles enforced after each emitted pulse, during which press events are discarded; must be >= 1

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
btn_up  input  1  raw asynchronous button, active-high
btn_left  input  1  raw asynchronous button, active-high
btn_down  input  1  raw asynchronous button, active-high
btn_right  input  1  raw asynchronous button, active-high
btn_cheat  input  1  raw asynchronous button, active-high
move_valid  output  1  one-cycle move command strobe
move_dir  output  2  direction: 0=up, 1=left, 2=down, 3=right; valid when move_valid=1
cheat_valid  output  1  one-cycle cheat command strobe
busy  output  1  high in FIRE and COOLDOWN states

Behaviour:
- Reset (reset_n=0 at a rising edge): move_valid=0, cheat_valid=0, move_dir=0, busy=0, state=IDLE. All synchroniser flops, debounced levels, previous-level copies and counters are cleared to 0. Reset has priority over every other event, including mid-debounce, FIRE and COOLDOWN.
- Per button, in order:
  - 2-flop synchroniser producing s.
  - Debounced level db and a counter of width clog2(DEBOUNCE_CYCLES+1).
    - If s == db: counter <= 0.
    - Else if counter == DEBOUNCE_CYCLES-1: db <= s and counter <= 0.
    - Else: counter <= counter+1.
  - db_prev <= db. press = db & ~db_prev (combinational, one cycle wide).
  - A mismatch shorter than DEBOUNCE_CYCLES cycles never changes db.
- Latency: raw input first sampled high at edge E0 and held -> db=1 after edge E0+DEBOUNCE_CYCLES+1 -> move_valid/cheat_valid high for the one cycle after edge E0+DEBOUNCE_CYCLES+2. Release is debounced symmetrically and produces no output.
- FSM:
  - IDLE:
    - If any press is high, register the command and go to FIRE.
    - Priority for same-cycle presses: cheat > up > left > down > right. Only the winner is emitted; losers are dropped.
  - FIRE: exactly one cycle.
    - Direction command: move_valid=1, move_dir=encoding.
    - Cheat command: cheat_valid=1, move_dir unchanged.
    - Next state is COOLDOWN with the cooldown counter loaded to 0.
  - COOLDOWN: counts COOLDOWN_CYCLES cycles, then goes to IDLE. Presses occurring in FIRE or COOLDOWN are discarded, not queued.
- move_valid and cheat_valid are never high simultaneously and never high on consecutive cycles. Minimum spacing between pulses is COOLDOWN_CYCLES+1 cycles.
- move_dir holds its last emitted value outside FIRE (reset value 0).
- A button held continuously produces exactly one pulse (edge-based, no auto-repeat).
- A button held through reset deassertion debounces to 1 after reset and yields one press.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=4.)
1. Reset, then raise btn_left sampled at edge E0 and hold 20 cycles -> move_valid=1 with move_dir=1 only in the cycle after E0+6; exactly one pulse in total; busy high 5 cycles.
2. btn_up high for 3 cycles then low (glitch) -> move_valid and cheat_valid stay 0 for 30 cycles; internal db_up never rises.
3. btn_down and btn_cheat raised at the same edge -> a single cheat_valid pulse; no move_valid; move_dir remains at its previous value.
4. Press btn_right (pulse at cycle T). Press btn_up so its press event lands at T+2, inside cooldown -> no up command. A fresh btn_up press landing at T+6 or later -> move_dir=0 pulse.
5. Sequence up, left, down, right with 20-cycle spacing driving a game_2048_core instance -> four pulses with move_dir 0,1,2,3, each pulse at least 5 cycles apart; core board_state changes after each.
6. Assert reset_n=0 while in COOLDOWN and while btn_left is held mid-debounce -> the next cycle has all outputs 0 and busy=0. After release with btn_left still held -> exactly one move_dir=1 pulse, DEBOUNCE_CYCLES+3 cycles after the first post-reset edge.
